// File: rtl/if_stage.sv
// Fetch stage and IF/ID pipeline register: next-PC selection, instruction latch,
// and saturating stall/flush counters for predictor evaluation.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PC_Write,
  input  logic             IFID_Write,
  input  logic             Flush,
  input  logic [31:0]      Redirect_PC,
  input  logic             Pred_Taken,
  input  logic [31:0]      Pred_Target,
  input  logic [31:0]      IMEM_Inst,
  output logic [31:0]      IMEM_Addr,
  output logic [31:0]      IFID_PC,
  output logic [31:0]      IFID_Inst,
  output logic             IFID_PredTaken,
  output logic             IFID_Valid,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam logic [31:0]      ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_inst_q, ifid_inst_d;
  logic             ifid_pred_q, ifid_pred_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Next PC: redirect beats prediction beats sequential fetch; targets are word-aligned
  always_comb begin
    pc_d = pc_q;
    if (Flush) begin
      pc_d = Redirect_PC & ALIGN_MASK;
    end else if (PC_Write && Pred_Taken) begin
      pc_d = Pred_Target & ALIGN_MASK;
    end else if (PC_Write) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // IF/ID register: a flush injects a bubble regardless of IFID_Write
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pred_d  = ifid_pred_q;
    ifid_valid_d = ifid_valid_q;
    if (Flush) begin
      ifid_pc_d    = 32'h0000_0000;
      ifid_inst_d  = NOP_INST;
      ifid_pred_d  = 1'b0;
      ifid_valid_d = 1'b0;
    end else if (IFID_Write) begin
      ifid_pc_d    = pc_q;
      ifid_inst_d  = IMEM_Inst;
      ifid_pred_d  = Pred_Taken;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_pc_d    = ifid_pc_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_pred_d  = ifid_pred_q;
      ifid_valid_d = ifid_valid_q;
    end
  end

  // Saturating counters; a stall coinciding with a flush is not a stall
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_Write && !Flush && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (Flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_inst_q  <= NOP_INST;
      ifid_pred_q  <= 1'b0;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pred_q  <= ifid_pred_d;
      ifid_valid_q <= ifid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign IMEM_Addr      = pc_q;
  assign IFID_PC        = ifid_pc_q;
  assign IFID_Inst      = ifid_inst_q;
  assign IFID_PredTaken = ifid_pred_q;
  assign IFID_Valid     = ifid_valid_q;
  assign Stall_Cnt      = stall_cnt_q;
  assign Flush_Cnt      = flush_cnt_q;

endmodule
